// File: rtl/point_mult_seq_pkg.sv
// ---------------------------------------------------------------------------
// elliptic_curve_structs
//   Shared types for the point multiplier:
//     curve_point_t   affine point (x, y), 256-bit coordinates
//     pm_state_t      sequencer states of point_mult_seq
//     is_negation()   true when b = -a (same x, different y)
// ---------------------------------------------------------------------------
package elliptic_curve_structs;

    localparam int COORD_W = 256;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        DBL_ISSUE = 3'd2,
        DBL_WAIT  = 3'd3,
        ADD_ISSUE = 3'd4,
        ADD_WAIT  = 3'd5,
        FIN       = 3'd6
    } pm_state_t;

    // Two affine points sharing x but not y sum to the point at infinity.
    function automatic logic is_negation(curve_point_t a, curve_point_t b);
        return (a.x == b.x) && (a.y != b.y);
    endfunction

endpackage

// File: rtl/point_mult_seq_if.sv
// ---------------------------------------------------------------------------
// point_mult_seq_if
//   Link between the point multiplier (master) and the external point-op
//   unit (slave).
//     op_reset   active-high unit reset; low while an op is running
//     op_double  1 = doubling of op_P, 0 = addition op_P + op_Q
//     op_P/op_Q  operands
//     op_done    result valid (held until op_reset)
//     op_R       result point
// ---------------------------------------------------------------------------
interface point_mult_seq_if;
    import elliptic_curve_structs::*;

    logic         op_reset;
    logic         op_double;
    curve_point_t op_P;
    curve_point_t op_Q;
    logic         op_done;
    curve_point_t op_R;

    modport master (
        output op_reset,
        output op_double,
        output op_P,
        output op_Q,
        input  op_done,
        input  op_R
    );

    modport slave (
        input  op_reset,
        input  op_double,
        input  op_P,
        input  op_Q,
        output op_done,
        output op_R
    );
endinterface

// File: rtl/point_mult_seq_leading_one.sv
// ---------------------------------------------------------------------------
// leading_one_256
//   Combinational leading-one detector.
//     vec    256-bit input
//     index  position of the most significant set bit (0 when vec = 0)
//     valid  vec has at least one set bit
// ---------------------------------------------------------------------------
module leading_one_256 (
    input  logic [255:0] vec,
    output logic [7:0]   index,
    output logic         valid
);
    always_comb begin
        index = '0;
        valid = |vec;
        // Ascending scan: the last hit is the most significant set bit.
        for (int b = 0; b < 256; b++) begin
            if (vec[b]) begin
                index = 8'(b);
            end
        end
    end
endmodule

// File: rtl/point_mult_seq.sv
// ---------------------------------------------------------------------------
// point_mult_seq
//   Sequential scalar multiplier R = k*P, left-to-right double-and-add,
//   driving an external point-op unit through point_mult_seq_if.
//   Ports:
//     clk, Reset_n    clock; synchronous active-low reset
//     Start, k, P     request pulse, 256-bit scalar, base point
//     Busy, Done      run in progress / result valid (held in FIN)
//     R, R_inf        result point, result is the point at infinity
//     op_bus          master side of the point-op unit link
//   Build option:
//     POINT_MULT_CONST_TIME_EN  scan all 256 bits from infinity, always
//                               issuing one doubling and one addition op per
//                               bit and discarding dummy results.
// ---------------------------------------------------------------------------
module point_mult_seq
    import elliptic_curve_structs::*;
(
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [255:0]     k,
    input  curve_point_t     P,
    output logic             Busy,
    output logic             Done,
    output curve_point_t     R,
    output logic             R_inf,
    point_mult_seq_if.master op_bus
);

`ifdef POINT_MULT_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    pm_state_t    state_reg, state_next;
    logic [255:0] k_reg, k_next;
    curve_point_t p_reg, p_next;
    curve_point_t a_reg, a_next;
    logic         a_inf_reg, a_inf_next;
    logic [7:0]   i_reg, i_next;
    logic         cnt_reg, cnt_next;
    curve_point_t r_reg, r_next;
    logic         r_inf_reg, r_inf_next;
    logic         op_double_reg, op_double_next;
    curve_point_t op_p_reg, op_p_next;
    curve_point_t op_q_reg, op_q_next;

    logic [7:0]   lod_index;
    logic         lod_valid;
    logic         enter_dbl, enter_add, dbl_done, add_done, bit_done;

    leading_one_256 u_lod (
        .vec   (k_reg),
        .index (lod_index),
        .valid (lod_valid)
    );

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            p_reg         <= '0;
            a_reg         <= '0;
            a_inf_reg     <= 1'b0;
            i_reg         <= '0;
            cnt_reg       <= 1'b0;
            r_reg         <= '0;
            r_inf_reg     <= 1'b0;
            op_double_reg <= 1'b0;
            op_p_reg      <= '0;
            op_q_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            p_reg         <= p_next;
            a_reg         <= a_next;
            a_inf_reg     <= a_inf_next;
            i_reg         <= i_next;
            cnt_reg       <= cnt_next;
            r_reg         <= r_next;
            r_inf_reg     <= r_inf_next;
            op_double_reg <= op_double_next;
            op_p_reg      <= op_p_next;
            op_q_reg      <= op_q_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        p_next         = p_reg;
        a_next         = a_reg;
        a_inf_next     = a_inf_reg;
        i_next         = i_reg;
        cnt_next       = cnt_reg;
        r_next         = r_reg;
        r_inf_next     = r_inf_reg;
        op_double_next = op_double_reg;
        op_p_next      = op_p_reg;
        op_q_next      = op_q_reg;
        enter_dbl      = 1'b0;
        enter_add      = 1'b0;
        dbl_done       = 1'b0;
        add_done       = 1'b0;
        bit_done       = 1'b0;

        case (state_reg)
            IDLE, FIN: begin
                if (Start) begin
                    k_next     = k;
                    p_next     = P;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (CONST_TIME) begin
                    a_next     = '0;
                    a_inf_next = 1'b1;
                    i_next     = 8'd255;
                    enter_dbl  = 1'b1;
                end else if (!lod_valid) begin
                    a_next     = '0;
                    a_inf_next = 1'b1;
                    state_next = FIN;
                end else begin
                    // The leading one is consumed by loading A = P directly.
                    a_next     = p_reg;
                    a_inf_next = 1'b0;
                    if (lod_index == 8'd0) begin
                        state_next = FIN;
                    end else begin
                        i_next    = lod_index - 8'd1;
                        enter_dbl = 1'b1;
                    end
                end
            end
            DBL_ISSUE: begin
                if (cnt_reg == 1'b0) begin
                    // Degenerate doublings resolve here with op_reset still high.
                    if (!CONST_TIME && (a_inf_reg || a_reg.y == '0)) begin
                        a_inf_next = 1'b1;
                        dbl_done   = 1'b1;
                    end else begin
                        cnt_next = 1'b1;
                    end
                end else begin
                    state_next = DBL_WAIT;
                end
            end
            DBL_WAIT: begin
                if (op_bus.op_done) begin
                    if (a_inf_reg || a_reg.y == '0) begin
                        a_inf_next = 1'b1;      // dummy op, result discarded
                    end else begin
                        a_next     = op_bus.op_R;
                        a_inf_next = 1'b0;
                    end
                    dbl_done = 1'b1;
                end
            end
            ADD_ISSUE: begin
                if (cnt_reg == 1'b0) begin
                    if (!CONST_TIME && a_inf_reg) begin
                        a_next     = p_reg;
                        a_inf_next = 1'b0;
                        add_done   = 1'b1;
                    end else if (!CONST_TIME && is_negation(a_reg, p_reg)) begin
                        a_inf_next = 1'b1;
                        add_done   = 1'b1;
                    end else begin
                        cnt_next = 1'b1;
                    end
                end else begin
                    state_next = ADD_WAIT;
                end
            end
            ADD_WAIT: begin
                if (op_bus.op_done) begin
                    // In the constant-time build every special case still ran
                    // a (dummy) op; its result is only kept when meaningful.
                    if (!k_reg[i_reg]) begin
                        a_next = a_reg;
                    end else if (a_inf_reg) begin
                        a_next     = p_reg;
                        a_inf_next = 1'b0;
                    end else if (is_negation(a_reg, p_reg)) begin
                        a_inf_next = 1'b1;
                    end else begin
                        a_next     = op_bus.op_R;
                        a_inf_next = 1'b0;
                    end
                    add_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (dbl_done) begin
            if (CONST_TIME || k_reg[i_reg]) begin
                enter_add = 1'b1;
            end else begin
                bit_done = 1'b1;
            end
        end
        if (add_done) begin
            bit_done = 1'b1;
        end
        if (bit_done) begin
            if (i_reg == 8'd0) begin
                state_next = FIN;
            end else begin
                i_next    = i_reg - 8'd1;
                enter_dbl = 1'b1;
            end
        end

        // Operands are loaded on entry to an ISSUE state and then held
        // constant through the matching WAIT state.
        if (enter_dbl) begin
            state_next     = DBL_ISSUE;
            cnt_next       = 1'b0;
            op_p_next      = a_next;
            op_q_next      = a_next;
            op_double_next = 1'b1;
        end
        if (enter_add) begin
            state_next     = ADD_ISSUE;
            cnt_next       = 1'b0;
            op_p_next      = a_next;
            op_q_next      = p_reg;
            op_double_next = (a_next == p_reg) && !a_inf_next;
        end

        if (state_next == FIN && state_reg != FIN) begin
            r_next     = a_next;
            r_inf_next = a_inf_next;
        end
    end

    assign Busy  = (state_reg != IDLE) && (state_reg != FIN);
    assign Done  = (state_reg == FIN);
    assign R     = r_reg;
    assign R_inf = r_inf_reg;

    assign op_bus.op_reset  = (state_reg != DBL_WAIT) && (state_reg != ADD_WAIT);
    assign op_bus.op_double = op_double_reg;
    assign op_bus.op_P      = op_p_reg;
    assign op_bus.op_Q      = op_q_reg;

endmodule

// File: doc/point_mult_seq.md
POINT_MULT_SEQ -- requirements
Module: point_mult_seq

Interface
REQ-001 SHALL have ports, in order: clk (in, 1, clock); Reset_n (in, 1, reset); one clock; reset is synchronous and active-low.
REQ-002 SHALL have Start (in, 1): request pulse; k (in, 256): scalar; P (in, curve_point_t): base point.
REQ-003 SHALL have Busy (out, 1); Done (out, 1); R (out, curve_point_t): result; R_inf (out, 1): result is the point at infinity.
REQ-004 SHALL drive the point-op unit through op_reset (out, 1, active-high unit reset), op_double (out, 1, 1 = doubling, 0 = addition), op_P and op_Q (out, curve_point_t), and SHALL receive op_done (in, 1) and op_R (in, curve_point_t).

Function
REQ-005 SHALL compute R = k*P by left-to-right double-and-add, holding accumulator A and flag A_inf.
REQ-006 SHALL use FSM states IDLE, SCAN, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, FIN.
REQ-007 SHALL accept Start only in IDLE or FIN, latch k and P, then go to SCAN with Busy=1 and Done=0; Start while Busy SHALL be ignored.
REQ-008 SCAN SHALL find the most significant set bit m of k; for k=0 it SHALL go to FIN with R_inf=1 and R=0, issuing no ops.
REQ-009 SCAN SHALL set A=P and A_inf=0 without an op, and set bit index i=m-1; if m=0 it SHALL go to FIN.
REQ-010 Per bit i: double A, then add P if k[i]=1; after bit 0 it SHALL go to FIN, otherwise it SHALL decrement i.
REQ-011 ISSUE states SHALL hold op_reset=1 for exactly 2 cycles with op_P, op_Q and op_double stable.
REQ-012 WAIT states SHALL hold op_reset=0 with operands unchanged, and SHALL capture op_R into A on the first cycle op_done=1.
REQ-013 Doubling with A_inf=1 or A.y=0 SHALL set A_inf=1 without issuing an op.
REQ-014 Addition with A_inf=1 SHALL set A=P and A_inf=0 without an op.
REQ-015 Addition with A.x=P.x and A.y=P.y SHALL issue a doubling op instead (op_double=1).
REQ-016 Addition with A.x=P.x and A.y≠P.y SHALL set A_inf=1 without an op.
REQ-017 On entering FIN, R and R_inf SHALL load from A and A_inf; FIN SHALL hold Done=1, Busy=0 and R stable until an accepted Start or reset.
REQ-018 Outside ISSUE and WAIT states, op_reset SHALL be 1.

Reset
REQ-019 On Reset_n=0 at a clock edge, the block SHALL enter IDLE with Done=0, Busy=0, R=0, R_inf=0, op_reset=1, op_double=0, op_P=0 and op_Q=0.
REQ-020 Reset mid-operation SHALL abort without completing; op_reset SHALL be 1 from the next cycle.

Configuration
REQ-021 Macro POINT_MULT_CONST_TIME_EN defined: the block SHALL scan all 256 bits starting from A_inf=1, and SHALL issue one doubling op and one addition op for every bit regardless of k or A_inf, discarding dummy results, for 512 ops per run.
REQ-022 Macro POINT_MULT_CONST_TIME_EN undefined: the block SHALL behave as in REQ-008 to REQ-016.

Structure
REQ-023 curve_point_t SHALL come from elliptic_curve_structs, and the FSM state enum SHALL be added to that package.
REQ-024 The 256-bit leading-one detector SHALL be a sub-module named leading_one_256 (combinational; outputs index and valid).
REQ-025 The point-op unit SHALL be external to this block; this block SHALL NOT instantiate it.

Verification
Bench: behavioral op unit with 10-cycle latency over y^2=x^3+2x+2 mod 17, P=(5,1), order 19.
REQ-026 k=0: Done within 4 cycles, R_inf=1, R=0, and op_reset never falls.
REQ-027 k=1: R=(5,1), R_inf=0, with zero ops issued.
REQ-028 k=2: exactly one doubling op, R=(6,3); k=9: R=(7,6).
REQ-029 k=19: R_inf=1, reached through the A.x=P.x, A.y≠P.y case at the final addition; k=18: R=(5,16).
REQ-030 Reset_n low for 1 cycle during DBL_WAIT of k=9: next cycle IDLE with op_reset=1; a fresh Start with k=9 then gives (7,6).
REQ-031 Macro POINT_MULT_CONST_TIME_EN defined, k=2: exactly 512 op_reset falling edges and R=(6,3); run length identical for k=9.
